// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer
// Receive side of a PS/2 keyboard port, running entirely in the system clock
// domain. The raw PS/2 clock and data pins are synchronised, and falling edges
// of the PS/2 clock drive an 11-bit frame sequencer (start, 8 data LSB first,
// odd parity, stop). E0/F0 prefix bytes are folded into per-key flags. Decoded
// keys are queued in a small first-word-fall-through FIFO with a valid/ready
// consumer interface.

module ps2_rx_sequencer #(
    parameter int SYNC_STAGES    = 2,     // synchroniser depth, at least 2
    parameter int TIMEOUT_CYCLES = 5000,  // max clocks between PS/2 falling edges in a frame
    parameter int FIFO_DEPTH     = 4      // decoded-key entries, power of 2, at least 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    code,
    output logic                          is_break,
    output logic                          is_ext,
    output logic                          valid,
    input  logic                          ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO entry layout: {ext, brk, scancode}
    localparam int ENTRY_W = 10;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    // Frame sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Pin synchronisers and PS/2 clock edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   prev_clk_q;

    logic sync_clk;
    logic sync_data;
    logic fall;

    assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
    assign sync_data = data_sync_q[SYNC_STAGES-1];
    // A falling PS/2 clock edge is the only moment the data pin is sampled.
    assign fall      = prev_clk_q & ~sync_clk;

    // Shift both pins through the synchroniser chains; reset to the idle-high
    // level so that leaving reset never looks like a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            prev_clk_q  <= sync_clk;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer state
    // ------------------------------------------------------------------
    logic [1:0]      state_q,   state_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q,   shift_d;
    logic            parity_q,  parity_d;
    logic [TO_W-1:0] timeout_q, timeout_d;
    logic            ext_q,     ext_d;
    logic            brk_q,     brk_d;
    logic            err_q,     err_d;

    logic                frame_good;
    logic                timed_out;
    logic                push_req;
    logic [ENTRY_W-1:0]  push_entry;

    // The stop bit is the live sampled data; parity is odd over data+parity.
    assign frame_good = sync_data & (^{shift_q, parity_q});

    // The frame is abandoned when the gap since the last falling edge reaches
    // the limit; a falling edge on that same cycle still counts as in time.
    assign timed_out  = (state_q != ST_IDLE) && !fall &&
                        (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic: frame sequencing, prefix folding and timeout handling.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        err_d      = 1'b0;
        push_req   = 1'b0;
        push_entry = {ext_q, brk_q, shift_q};

        // Inter-edge gap counter only runs while a frame is in flight.
        if (state_q == ST_IDLE || fall) begin
            timeout_d = '0;
        end else begin
            timeout_d = timeout_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // A high sample is just line noise or an idle edge; ignore it.
                if (fall && !sync_data) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end

            ST_DATA: begin
                if (fall) begin
                    shift_d[bit_idx_q] = sync_data;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end

            ST_PARITY: begin
                if (fall) begin
                    parity_d = sync_data;
                    state_d  = ST_STOP;
                end
            end

            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (frame_good) begin
                        if (shift_q == BYTE_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == BYTE_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            // Prefixes are consumed by this key whether or not
                            // the FIFO has room for it.
                            push_req = 1'b1;
                            ext_d    = 1'b0;
                            brk_d    = 1'b0;
                        end
                    end else begin
                        // A corrupted frame may have been the key a pending
                        // prefix belonged to, so the prefix is discarded too.
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timed_out) begin
            err_d     = 1'b1;
            state_d   = ST_IDLE;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
            timeout_d = '0;
        end
    end

    // Register the sequencer state and the one-cycle error pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            timeout_q <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            timeout_q <= timeout_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            err_q     <= err_d;
        end
    end

    assign frame_err = err_q;

    // ------------------------------------------------------------------
    // Decoded-key FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               ovf_q,    ovf_d;

    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic [ENTRY_W-1:0] head_entry;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = valid & ready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign push_ok   = push_req & (~fifo_full | pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_req & fifo_full & ~pop;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array: written only, never reset, so it maps onto plain memory.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // Register FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Head of queue, masked to zero when empty so stale or uninitialised
    // storage never reaches the consumer.
    assign head_entry = fifo_mem[rd_ptr_q];
    assign valid      = (count_q != '0);
    assign code       = valid ? head_entry[7:0] : 8'h00;
    assign is_break   = valid & head_entry[8];
    assign is_ext     = valid & head_entry[9];
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Directed testbench for ps2_rx_sequencer. A host-side PS/2 keyboard model
// drives frames; a monitor records every accepted key, error and overflow
// pulse; the main sequence compares against hand-computed expectations.

`timescale 1ns/1ps

module tb_ps2_rx_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int FIFO_DEPTH     = 4;
    localparam int HALF           = 8;   // system clocks per PS/2 clock half-period

    logic       clock;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       is_break;
    logic       is_ext;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;

    int checks;
    int failures;

    // Monitor state
    logic [9:0] pops[$];     // accepted entries as {is_ext, is_break, code}
    int         err_cnt;
    int         ovf_cnt;
    int         valid_cycles;

    ps2_rx_sequencer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling clock edge; the monitor looks 2 ns later,
    // so it sees this cycle's ready and outputs settled since the last rise.
    always @(negedge clock) begin
        #2;
        if (reset_n) begin
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
            if (valid)     valid_cycles++;
            if (valid && ready) begin
                pops.push_back({is_ext, is_break, code});
                $display("tb: accepted code=0x%02h brk=%0d ext=%0d", code, is_break, is_ext);
            end
        end
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pop_at(input int i);
        if (i < pops.size()) return pops[i];
        return 10'h3FF;
    endfunction

    task automatic clear_monitor();
        pops.delete();
        err_cnt      = 0;
        ovf_cnt      = 0;
        valid_cycles = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One PS/2 bit: data set while the line is high, then a low half-period.
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full frame. bad_par inverts the parity bit. pop_at_stop raises ready
    // for exactly the cycle in which the stop-bit edge, having crossed the
    // synchroniser and edge register, is acted on.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_data = 1'b1;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        if (pop_at_stop) begin
            wait_cycles(SYNC_STAGES);
            ready = 1'b1;
            wait_cycles(1);
            ready = 1'b0;
            wait_cycles(HALF - SYNC_STAGES - 1);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b1;
        wait_cycles(10);
        $display("tb: sent frame 0x%02h bad_parity=%0d", b, bad_par);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_monitor();
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b1;

        // ---- Reset state ----
        wait_cycles(5);
        check("rst_code",      {24'd0, code},       32'h00);
        check("rst_valid",     {31'd0, valid},      32'd0);
        check("rst_flags",     {30'd0, is_ext, is_break}, 32'd0);
        check("rst_err_ovf",   {30'd0, frame_err, overflow}, 32'd0);
        check("rst_count",     {29'd0, fifo_count}, 32'd0);
        reset_n = 1'b1;
        wait_cycles(5);

        // ---- Plain key 0x1C ----
        clear_monitor();
        send_frame(8'h1C, 1'b0, 1'b0);
        check("key1c_pops",    pops.size(), 1);
        check("key1c_entry",   {22'd0, pop_at(0)}, {22'd0, 2'b00, 8'h1C});
        check("key1c_validcy", valid_cycles, 1);
        check("key1c_err",     err_cnt, 0);

        // ---- Break prefix: F0 1C ----
        clear_monitor();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("brk_pops",  pops.size(), 1);
        check("brk_entry", {22'd0, pop_at(0)}, {22'd0, 2'b01, 8'h1C});

        // ---- Extended break: E0 F0 75 ----
        clear_monitor();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("extbrk_pops",  pops.size(), 1);
        check("extbrk_entry", {22'd0, pop_at(0)}, {22'd0, 2'b11, 8'h75});

        // ---- Bad parity ----
        clear_monitor();
        send_frame(8'h1C, 1'b1, 1'b0);
        check("badpar_err",  err_cnt, 1);
        check("badpar_pops", pops.size(), 0);

        // ---- Bad frame clears a pending break prefix ----
        clear_monitor();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("pfxclr_err",   err_cnt, 1);
        check("pfxclr_pops",  pops.size(), 1);
        check("pfxclr_entry", {22'd0, pop_at(0)}, {22'd0, 2'b00, 8'h1C});

        // ---- Inter-bit timeout ----
        clear_monitor();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(TIMEOUT_CYCLES - 100);
        check("tmo_early", err_cnt, 0);
        wait_cycles(300);
        check("tmo_fired", err_cnt, 1);
        wait_cycles(50);
        check("tmo_once",  err_cnt, 1);
        send_frame(8'h29, 1'b0, 1'b0);
        check("tmo_next_pops",  pops.size(), 1);
        check("tmo_next_entry", {22'd0, pop_at(0)}, {22'd0, 2'b00, 8'h29});
        check("tmo_next_err",   err_cnt, 1);

        // ---- Fill and overflow ----
        clear_monitor();
        ready = 1'b0;
        send_frame(8'h16, 1'b0, 1'b0);
        send_frame(8'h1E, 1'b0, 1'b0);
        send_frame(8'h26, 1'b0, 1'b0);
        send_frame(8'h25, 1'b0, 1'b0);
        check("fill_count", {29'd0, fifo_count}, 32'd4);
        check("fill_head",  {24'd0, code}, 32'h16);
        check("fill_ovf",   ovf_cnt, 0);
        send_frame(8'h2E, 1'b0, 1'b0);
        check("ovf_pulse",  ovf_cnt, 1);
        check("ovf_count",  {29'd0, fifo_count}, 32'd4);
        ready = 1'b1;
        wait_cycles(8);
        check("drain_pops",  pops.size(), 4);
        check("drain_0",     {22'd0, pop_at(0)}, {22'd0, 10'h016});
        check("drain_1",     {22'd0, pop_at(1)}, {22'd0, 10'h01E});
        check("drain_2",     {22'd0, pop_at(2)}, {22'd0, 10'h026});
        check("drain_3",     {22'd0, pop_at(3)}, {22'd0, 10'h025});
        check("drain_count", {29'd0, fifo_count}, 32'd0);

        // ---- Push and pop on the same cycle while full ----
        clear_monitor();
        ready = 1'b0;
        send_frame(8'h15, 1'b0, 1'b0);
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h24, 1'b0, 1'b0);
        send_frame(8'h2D, 1'b0, 1'b0);
        check("simul_pre_count", {29'd0, fifo_count}, 32'd4);
        send_frame(8'h2C, 1'b0, 1'b1);
        check("simul_ovf",   ovf_cnt, 0);
        check("simul_count", {29'd0, fifo_count}, 32'd4);
        check("simul_pop0",  {22'd0, pop_at(0)}, {22'd0, 10'h015});
        ready = 1'b1;
        wait_cycles(8);
        ready = 1'b0;
        check("simul_pops", pops.size(), 5);
        check("simul_pop1", {22'd0, pop_at(1)}, {22'd0, 10'h01D});
        check("simul_last", {22'd0, pop_at(4)}, {22'd0, 10'h02C});

        // ---- Reset in the middle of a frame ----
        clear_monitor();
        send_frame(8'h1C, 1'b0, 1'b0);
        check("mid_pre_valid", {31'd0, valid}, 32'd1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        wait_cycles(2);
        reset_n = 1'b0;
        #1;
        check("mid_valid", {31'd0, valid},      32'd0);
        check("mid_code",  {24'd0, code},       32'h00);
        check("mid_count", {29'd0, fifo_count}, 32'd0);
        check("mid_flags", {28'd0, is_ext, is_break, frame_err, overflow}, 32'd0);
        ps2_data = 1'b1;
        wait_cycles(3);
        reset_n = 1'b1;
        ready   = 1'b1;
        wait_cycles(5);
        clear_monitor();
        send_frame(8'h1B, 1'b0, 1'b0);
        check("mid_next_pops",  pops.size(), 1);
        check("mid_next_entry", {22'd0, pop_at(0)}, {22'd0, 10'h01B});
        check("mid_next_err",   err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
